decoder_proj_formal: RTL and testbench

DECODER_PROJ_FORMAL -- requirements
Module: decoder_proj_formal

---
 rtl/decoder_proj_pkg.sv | 30 +++
 rtl/seg7_lookup.sv | 29 ++
 rtl/decoder_proj_formal.sv | 121 ++++++++++++
 tb/tb_decoder_proj_formal.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_proj_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : decoder_proj_pkg                                            |
// | Brief   : Shared constants, glyph table and types for the 7-seg decoder|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package decoder_proj_pkg;

   localparam int ERR_CNT_W   = 8;
   localparam int SYNC_STAGES = 2;
   localparam int SEG_W       = 7;
   localparam int DIGIT_W     = 4;
   localparam int NUM_GLYPHS  = 16;

   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Active-high segment patterns {a,b,c,d,e,f,g}; entry i decodes to hex digit i.
   localparam logic [NUM_GLYPHS-1:0][SEG_W-1:0] GLYPH_TABLE = {
      7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
      7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
   };

   typedef enum logic [1:0] {
      CLS_BLANK = 2'd0,
      CLS_LEGAL = 2'd1,
      CLS_ERR   = 2'd2
   } seg_class_e;

endpackage
`default_nettype wire

// File: rtl/seg7_lookup.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : seg7_lookup                                                 |
// | Brief   : Combinational active-high 7-segment glyph to hex lookup     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module seg7_lookup
   import decoder_proj_pkg::*;
(
   input  logic [SEG_W-1:0]   i_p,
   output logic [DIGIT_W-1:0] o_digit,
   output logic               o_legal,
   output logic               o_blank
);

   always_comb begin
      o_digit = '0;
      o_legal = 1'b0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
         if (i_p == GLYPH_TABLE[i]) begin
            o_digit = DIGIT_W'(i);
            o_legal = 1'b1;
         end
      end
      o_blank = (i_p == '0);
   end

endmodule
`default_nettype wire

// File: rtl/decoder_proj_formal.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : decoder_proj_formal                                         |
// | Brief   : Synchronized 7-segment pattern decoder with error counter   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module decoder_proj_formal
   import decoder_proj_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEG_W-1:0]     io_in,
   output logic [DIGIT_W-1:0]   digit,
   output logic                 valid,
   output logic                 blank,
   output logic                 err,
   output logic                 chg,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [SEG_W-1:0]     r_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] r_fill;
   logic [DIGIT_W-1:0]   r_digit;
   logic                 r_valid;
   logic                 r_blank;
   logic                 r_err;
   logic                 r_chg;
   logic                 r_first;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic [SEG_W-1:0]     w_p;
   logic [DIGIT_W-1:0]   w_digit;
   logic                 w_legal;
   logic                 w_blank;
   seg_class_e           w_class;

   // r_fill marks when the synchronizer holds post-reset samples, so the
   // reset value of the flops is never decoded as a glyph.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_fill <= '0;
      end else begin
         r_sync[0] <= io_in;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign w_p = ACTIVE_LOW ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];

   seg7_lookup u_lookup (
      .i_p     (w_p),
      .o_digit (w_digit),
      .o_legal (w_legal),
      .o_blank (w_blank)
   );

   always_comb begin
      w_class = CLS_ERR;
      if (w_legal)      w_class = CLS_LEGAL;
      else if (w_blank) w_class = CLS_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit   <= '0;
         r_valid   <= 1'b0;
         r_blank   <= 1'b0;
         r_err     <= 1'b0;
         r_chg     <= 1'b0;
         r_first   <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_chg <= 1'b0;
         if (r_fill[SYNC_STAGES-1]) begin
            r_valid <= (w_class == CLS_LEGAL);
            r_blank <= (w_class == CLS_BLANK);
            r_err   <= (w_class == CLS_ERR);
            if (w_class == CLS_LEGAL) begin
               r_digit <= w_digit;
               r_first <= 1'b1;
               r_chg   <= !r_first || (w_digit != r_digit);
            end
            if ((w_class == CLS_ERR) && (r_err_cnt != ERR_CNT_MAX))
               r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign digit   = r_digit;
   assign valid   = r_valid;
   assign blank   = r_blank;
   assign err     = r_err;
   assign chg     = r_chg;
   assign err_cnt = r_err_cnt;

`ifdef FORMAL
   logic [1:0] r_f_age;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_f_age <= 2'd0;
      else if (r_f_age != 2'd3) r_f_age <= r_f_age + 2'd1;
   end

   a_onehot_class: assert property (@(posedge clk) disable iff (!rst_n)
      (r_f_age == 2'd3) |-> $onehot({valid, blank, err}));

   for (genvar gi = 0; gi < NUM_GLYPHS; gi++) begin : g_cover_digit
      c_digit: cover property (@(posedge clk) valid && (digit == DIGIT_W'(gi)));
   end

   c_blank:   cover property (@(posedge clk) blank);
   c_err:     cover property (@(posedge clk) err);
   c_err_sat: cover property (@(posedge clk) err_cnt == ERR_CNT_MAX);
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_proj_formal.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_decoder_proj_formal                                      |
// | Brief   : Self-checking bench for both segment polarities             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_decoder_proj_formal;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] io_in = '0;

   logic [3:0] al_digit, ah_digit;
   logic       al_valid, al_blank, al_err, al_chg;
   logic       ah_valid, ah_blank, ah_err, ah_chg;
   logic [7:0] al_err_cnt, ah_err_cnt;

   always #5 clk = ~clk;

   decoder_proj_formal #(.ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst_n(rst_n), .io_in(io_in), .digit(al_digit), .valid(al_valid),
      .blank(al_blank), .err(al_err), .chg(al_chg), .err_cnt(al_err_cnt));

   decoder_proj_formal #(.ACTIVE_LOW(1'b0)) u_dut_ah (
      .clk(clk), .rst_n(rst_n), .io_in(io_in), .digit(ah_digit), .valid(ah_valid),
      .blank(ah_blank), .err(ah_err), .chg(ah_chg), .err_cnt(ah_err_cnt));

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] gly [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   typedef struct packed {
      logic [3:0] digit;
      logic       valid;
      logic       blank;
      logic       err;
      logic       chg;
      logic       first;
      logic [7:0] cnt;
   } mstate_t;

   mstate_t    m_al, m_ah;
   logic [6:0] pipe [$];

   // Reference: each raw sample appears on the outputs three edges after capture.
   function automatic mstate_t step(input mstate_t s, input logic [6:0] raw, input bit al);
      mstate_t    r;
      logic [6:0] p;
      int         idx;
      r   = s;
      p   = al ? ~raw : raw;
      idx = -1;
      for (int k = 0; k < 16; k++) if (gly[k] == p) idx = k;
      r.chg = 1'b0;
      if (idx >= 0) begin
         r.chg   = !s.first || (s.digit != 4'(idx));
         r.digit = 4'(idx);
         r.valid = 1'b1; r.blank = 1'b0; r.err = 1'b0; r.first = 1'b1;
      end else if (p == 7'h00) begin
         r.valid = 1'b0; r.blank = 1'b1; r.err = 1'b0;
      end else begin
         r.valid = 1'b0; r.blank = 1'b0; r.err = 1'b1;
         if (r.cnt != 8'd255) r.cnt = r.cnt + 8'd1;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe.delete();
         m_al = '0;
         m_ah = '0;
      end else begin
         m_al.chg = 1'b0;
         m_ah.chg = 1'b0;
         pipe.push_back(io_in);
         if (pipe.size() >= 3) begin
            logic [6:0] v;
            v    = pipe.pop_front();
            m_al = step(m_al, v, 1'b1);
            m_ah = step(m_ah, v, 1'b0);
         end
      end
   end

   logic [15:0] obs_al, obs_ah, exp_al, exp_ah;
   assign obs_al = {al_digit, al_valid, al_blank, al_err, al_chg, al_err_cnt};
   assign obs_ah = {ah_digit, ah_valid, ah_blank, ah_err, ah_chg, ah_err_cnt};
   assign exp_al = {m_al.digit, m_al.valid, m_al.blank, m_al.err, m_al.chg, m_al.cnt};
   assign exp_ah = {m_ah.digit, m_ah.valid, m_ah.blank, m_ah.err, m_ah.chg, m_ah.cnt};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      io_in = 7'($urandom);
      tick(); tick();
      n_cmp++;
      if (obs_al !== 16'h0000) begin
         n_bad++; $display("FAIL reset_al: got %h want %h", obs_al, 16'h0000);
      end
      n_cmp++;
      if (obs_ah !== 16'h0000) begin
         n_bad++; $display("FAIL reset_ah: got %h want %h", obs_ah, 16'h0000);
      end
   endtask

   task automatic test_hold_one();
      int chg_cnt;
      int first_valid;
      chg_cnt = 0;
      first_valid = -1;
      io_in = 7'b1001111;
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (al_chg) chg_cnt++;
         if (al_valid && first_valid < 0) first_valid = i;
         n_cmp++;
         if (obs_al !== exp_al) begin
            n_bad++; $display("FAIL hold_one_al cyc %0d: got %h want %h", i, obs_al, exp_al);
         end
         n_cmp++;
         if (obs_ah !== exp_ah) begin
            n_bad++; $display("FAIL hold_one_ah cyc %0d: got %h want %h", i, obs_ah, exp_ah);
         end
      end
      n_cmp++;
      if (first_valid !== 3) begin
         n_bad++; $display("FAIL hold_one_latency: got %0d want %0d", first_valid, 3);
      end
      n_cmp++;
      if (chg_cnt !== 1) begin
         n_bad++; $display("FAIL hold_one_chg_count: got %0d want %0d", chg_cnt, 1);
      end
      n_cmp++;
      if ({al_digit, al_valid} !== {4'h1, 1'b1}) begin
         n_bad++; $display("FAIL hold_one_digit_al: got %h/%b want 1/1", al_digit, al_valid);
      end
      n_cmp++;
      if ({ah_digit, ah_valid} !== {4'hE, 1'b1}) begin
         n_bad++; $display("FAIL hold_one_digit_ah: got %h/%b want e/1", ah_digit, ah_valid);
      end
   endtask

   task automatic test_blank_ah();
      io_in = 7'b0000000;
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_cmp++;
         if (obs_al !== exp_al) begin
            n_bad++; $display("FAIL blank_al cyc %0d: got %h want %h", i, obs_al, exp_al);
         end
         n_cmp++;
         if (obs_ah !== exp_ah) begin
            n_bad++; $display("FAIL blank_ah cyc %0d: got %h want %h", i, obs_ah, exp_ah);
         end
      end
      n_cmp++;
      if ({ah_blank, ah_valid, ah_err, ah_digit} !== {3'b100, 4'hE}) begin
         n_bad++;
         $display("FAIL blank_hold_ah: got b%b v%b e%b d%h want b1 v0 e0 de",
                  ah_blank, ah_valid, ah_err, ah_digit);
      end
   endtask

   task automatic test_sweep();
      int chg_cnt;
      chg_cnt = 0;
      for (int g = 0; g < 16; g++) begin
         io_in = ~gly[g];
         for (int i = 0; i < 4; i++) begin
            tick();
            if (al_chg) chg_cnt++;
            n_cmp++;
            if (obs_al !== exp_al) begin
               n_bad++; $display("FAIL sweep_al g%0d cyc %0d: got %h want %h", g, i, obs_al, exp_al);
            end
            n_cmp++;
            if (obs_ah !== exp_ah) begin
               n_bad++; $display("FAIL sweep_ah g%0d cyc %0d: got %h want %h", g, i, obs_ah, exp_ah);
            end
         end
         n_cmp++;
         if (al_digit !== 4'(g)) begin
            n_bad++; $display("FAIL sweep_digit g%0d: got %h want %h", g, al_digit, 4'(g));
         end
      end
      n_cmp++;
      if (chg_cnt !== 16) begin
         n_bad++; $display("FAIL sweep_chg_count: got %0d want %0d", chg_cnt, 16);
      end
   endtask

   task automatic test_err_sat();
      io_in = 7'b1111110;
      for (int i = 1; i <= 300; i++) begin
         tick();
         n_cmp++;
         if (obs_al !== exp_al) begin
            n_bad++; $display("FAIL err_sat_al cyc %0d: got %h want %h", i, obs_al, exp_al);
         end
         n_cmp++;
         if (obs_ah !== exp_ah) begin
            n_bad++; $display("FAIL err_sat_ah cyc %0d: got %h want %h", i, obs_ah, exp_ah);
         end
      end
      n_cmp++;
      if ({al_err_cnt, al_err, al_valid, al_digit} !== {8'd255, 1'b1, 1'b0, 4'hF}) begin
         n_bad++;
         $display("FAIL err_sat_final: got cnt %0d err %b valid %b digit %h want cnt 255 err 1 valid 0 digit f",
                  al_err_cnt, al_err, al_valid, al_digit);
      end
   endtask

   task automatic test_reset_mid();
      int chg_cnt;
      chg_cnt = 0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_al !== 16'h0000) begin
         n_bad++; $display("FAIL reset_mid_al: got %h want %h", obs_al, 16'h0000);
      end
      n_cmp++;
      if (obs_ah !== 16'h0000) begin
         n_bad++; $display("FAIL reset_mid_ah: got %h want %h", obs_ah, 16'h0000);
      end
      @(negedge clk);
      io_in = ~gly[5];
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (al_chg) chg_cnt++;
         n_cmp++;
         if (obs_al !== exp_al) begin
            n_bad++; $display("FAIL reset_mid_run_al cyc %0d: got %h want %h", i, obs_al, exp_al);
         end
      end
      n_cmp++;
      if ({chg_cnt, al_digit} !== {32'd1, 4'h5}) begin
         n_bad++; $display("FAIL reset_mid_first: got chg %0d digit %h want chg 1 digit 5", chg_cnt, al_digit);
      end
   endtask

   task automatic test_back_to_back();
      int chg_cnt;
      logic [6:0] seq [3];
      chg_cnt = 0;
      seq[0] = ~gly[1];
      seq[1] = 7'h7F;
      seq[2] = ~gly[1];
      for (int s = 0; s < 3; s++) begin
         io_in = seq[s];
         for (int i = 0; i < 4; i++) begin
            tick();
            if (al_chg) chg_cnt++;
            n_cmp++;
            if (obs_al !== exp_al) begin
               n_bad++; $display("FAIL repeat_al s%0d cyc %0d: got %h want %h", s, i, obs_al, exp_al);
            end
         end
      end
      n_cmp++;
      if (chg_cnt !== 1) begin
         n_bad++; $display("FAIL repeat_chg_count: got %0d want %0d", chg_cnt, 1);
      end
   endtask

   task automatic test_random();
      int hold;
      int r;
      for (int i = 0; i < 400; i++) begin
         if (hold == 0) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      io_in = ~gly[$urandom_range(0, 15)];
            else if (r < 60) io_in = gly[$urandom_range(0, 15)];
            else if (r < 70) io_in = 7'h7F;
            else if (r < 80) io_in = 7'h00;
            else             io_in = 7'($urandom);
            hold = int'($urandom_range(1, 4));
         end
         hold--;
         tick();
         n_cmp++;
         if (obs_al !== exp_al) begin
            n_bad++; $display("FAIL random_al cyc %0d: got %h want %h", i, obs_al, exp_al);
         end
         n_cmp++;
         if (obs_ah !== exp_ah) begin
            n_bad++; $display("FAIL random_ah cyc %0d: got %h want %h", i, obs_ah, exp_ah);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_hold_one();
      test_blank_ah();
      test_sweep();
      test_err_sat();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
